// File: rtl/fetch_pfb_if.sv
// Bundle of fetch-stage signals between the prefetch buffer, imem_ctrl, the
// redirect source and DEC; the master side is the prefetch buffer itself.
interface fetch_pfb_if #(
   parameter int ADDR_WIDTH  = 32,
   parameter int INSTR_WIDTH = 32
) ();
   logic [ADDR_WIDTH-1:0]  boot_addr;
   logic                   redirect;
   logic [ADDR_WIDTH-1:0]  redirect_pc;
   logic                   halt;
   logic                   imem_req;
   logic [ADDR_WIDTH-1:0]  imem_addr;
   logic                   imem_gnt;
   logic                   imem_rvalid;
   logic [INSTR_WIDTH-1:0] imem_rdata;
   logic                   if_valid;
   logic [INSTR_WIDTH-1:0] instr_dec;
   logic [ADDR_WIDTH-1:0]  pc_dec;
   logic [ADDR_WIDTH-1:0]  pc_plus4_dec;
   logic                   dec_ready;
   logic                   pc_misaligned;
   logic [ADDR_WIDTH-1:0]  fault_pc;

   modport master (
      input  boot_addr, redirect, redirect_pc, halt,
      input  imem_gnt, imem_rvalid, imem_rdata, dec_ready,
      output imem_req, imem_addr, if_valid, instr_dec, pc_dec, pc_plus4_dec,
      output pc_misaligned, fault_pc
   );

   modport slave (
      output boot_addr, redirect, redirect_pc, halt,
      output imem_gnt, imem_rvalid, imem_rdata, dec_ready,
      input  imem_req, imem_addr, if_valid, instr_dec, pc_dec, pc_plus4_dec,
      input  pc_misaligned, fault_pc
   );
endinterface

// File: rtl/fetch_pfb.sv
// Prefetching instruction fetch stage: sequential PC generation, pipelined imem
// requests and a registered prefetch FIFO toward DEC, with flush-and-redirect.
module fetch_pfb #(
   parameter int ADDR_WIDTH  = 32,
   parameter int INSTR_WIDTH = 32,
   parameter int DEPTH       = 4,
   parameter int MAX_OUTST   = 2
) (
   input logic         cpu_clk,
   input logic         cpu_rstn,
   fetch_pfb_if.master bus
);
   localparam int PW   = $clog2(DEPTH);
   localparam int CNTW = PW + 1;
   localparam int CW   = PW + 2;
   localparam int OW   = $clog2(MAX_OUTST + 1);
   localparam int TW   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(32'd4);

   logic [ADDR_WIDTH-1:0]  r_fetch_pc;
   logic [OW-1:0]          r_outst;
   logic [OW-1:0]          r_drop;
   logic [INSTR_WIDTH-1:0] r_fifo_instr [DEPTH];
   logic [ADDR_WIDTH-1:0]  r_fifo_pc    [DEPTH];
   logic [PW-1:0]          r_rd_ptr;
   logic [PW-1:0]          r_wr_ptr;
   logic [CNTW-1:0]        r_count;
   logic [ADDR_WIDTH-1:0]  r_tag [MAX_OUTST];
   logic [TW-1:0]          r_tag_rd;
   logic [TW-1:0]          r_tag_wr;
   logic [INSTR_WIDTH-1:0] r_hold_instr;
   logic [ADDR_WIDTH-1:0]  r_hold_pc;

   logic                   w_misaligned;
   logic [CW-1:0]          w_occupancy;
   logic                   w_req;
   logic                   w_grant;
   logic                   w_rsp;
   logic                   w_push;
   logic                   w_nonempty;
   logic                   w_pop;
   logic [ADDR_WIDTH-1:0]  w_pc_dec;

   function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] ptr);
      if (ptr == TW'(MAX_OUTST - 1)) begin
         return {TW{1'b0}};
      end else begin
         return ptr + TW'(1);
      end
   endfunction

   // Slots already promised to in-flight requests count as occupied, so a response always fits.
   assign w_misaligned = (r_fetch_pc[1:0] != 2'b00);
   assign w_occupancy  = CW'(r_count) + CW'(r_outst);
   assign w_req        = cpu_rstn && !bus.redirect && !bus.halt && !w_misaligned &&
                         (r_outst < OW'(MAX_OUTST)) && (w_occupancy < CW'(DEPTH));
   assign w_grant      = w_req && bus.imem_gnt;
   assign w_rsp        = bus.imem_rvalid && (r_outst != {OW{1'b0}});
   assign w_push       = w_rsp && !bus.redirect && (r_drop == {OW{1'b0}});
   assign w_nonempty   = (r_count != {CNTW{1'b0}});
   assign w_pop        = w_nonempty && bus.dec_ready && !bus.redirect;
   assign w_pc_dec     = w_nonempty ? r_fifo_pc[r_rd_ptr] : r_hold_pc;

   assign bus.imem_req      = w_req;
   assign bus.imem_addr     = r_fetch_pc;
   assign bus.if_valid      = w_nonempty;
   assign bus.instr_dec     = w_nonempty ? r_fifo_instr[r_rd_ptr] : r_hold_instr;
   assign bus.pc_dec        = w_pc_dec;
   assign bus.pc_plus4_dec  = w_pc_dec + PC_STEP;
   assign bus.pc_misaligned = w_misaligned;
   assign bus.fault_pc      = w_misaligned ? r_fetch_pc : {ADDR_WIDTH{1'b0}};

   // Fetch PC, outstanding-request count and stale-response drop count.
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         r_fetch_pc <= bus.boot_addr;
         r_outst    <= {OW{1'b0}};
         r_drop     <= {OW{1'b0}};
      end else begin
         if (bus.redirect) begin
            r_fetch_pc <= bus.redirect_pc;
         end else if (w_grant) begin
            r_fetch_pc <= r_fetch_pc + PC_STEP;
         end
         case ({w_grant, w_rsp})
            2'b10:   r_outst <= r_outst + OW'(1);
            2'b01:   r_outst <= r_outst - OW'(1);
            default: r_outst <= r_outst;
         endcase
         if (bus.redirect) begin
            r_drop <= r_outst - OW'(w_rsp);
         end else if (w_rsp && (r_drop != {OW{1'b0}})) begin
            r_drop <= r_drop - OW'(1);
         end
      end
   end

   // Address tags of granted requests; stale tags are discarded wholesale on redirect.
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         r_tag_rd <= {TW{1'b0}};
         r_tag_wr <= {TW{1'b0}};
         for (int i = 0; i < MAX_OUTST; i++) begin
            r_tag[i] <= {ADDR_WIDTH{1'b0}};
         end
      end else if (bus.redirect) begin
         r_tag_rd <= {TW{1'b0}};
         r_tag_wr <= {TW{1'b0}};
      end else begin
         if (w_grant) begin
            r_tag[r_tag_wr] <= r_fetch_pc;
            r_tag_wr        <= tag_next(r_tag_wr);
         end
         if (w_push) begin
            r_tag_rd <= tag_next(r_tag_rd);
         end
      end
   end

   // Prefetch FIFO storage and pointers.
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         r_rd_ptr <= {PW{1'b0}};
         r_wr_ptr <= {PW{1'b0}};
         r_count  <= {CNTW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            r_fifo_instr[i] <= {INSTR_WIDTH{1'b0}};
            r_fifo_pc[i]    <= {ADDR_WIDTH{1'b0}};
         end
      end else if (bus.redirect) begin
         r_rd_ptr <= {PW{1'b0}};
         r_wr_ptr <= {PW{1'b0}};
         r_count  <= {CNTW{1'b0}};
      end else begin
         if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= bus.imem_rdata;
            r_fifo_pc[r_wr_ptr]    <= r_tag[r_tag_rd];
            r_wr_ptr               <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
      end
   end

   // Last presented head, shown to DEC while the FIFO is empty.
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         r_hold_instr <= {INSTR_WIDTH{1'b0}};
         r_hold_pc    <= bus.boot_addr;
      end else if (w_nonempty) begin
         r_hold_instr <= r_fifo_instr[r_rd_ptr];
         r_hold_pc    <= r_fifo_pc[r_rd_ptr];
      end
   end
endmodule

// File: tb/tb_fetch_pfb.sv
// Randomised scoreboard bench for fetch_pfb: the bench plays imem, predicts the
// delivered instruction stream from fetch epochs and compares it at DEC.
module tb_fetch_pfb;
   localparam int AW        = 32;
   localparam int IW        = 32;
   localparam int DEPTH     = 4;
   localparam int MAX_OUTST = 2;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] pc;
      int          epoch;
      int          due;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic clk;
   logic rstn;

   fetch_pfb_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

   fetch_pfb #(
      .ADDR_WIDTH (AW),
      .INSTR_WIDTH(IW),
      .DEPTH      (DEPTH),
      .MAX_OUTST  (MAX_OUTST)
   ) dut (
      .cpu_clk (clk),
      .cpu_rstn(rstn),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   req_t        pending[$];
   exp_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          epoch = 0;
   int          pops = 0;
   int          grants = 0;
   int          first_valid = -1;
   logic [31:0] req_pc;
   bit          mis = 1'b0;
   bit          mon_en = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic do_reset(input logic [31:0] boot);
      @(negedge clk);
      rstn = 1'b0;
      mon_en = 1'b0;
      bus.boot_addr = boot;
      bus.redirect = 1'b0;
      bus.halt = 1'b0;
      bus.imem_gnt = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.dec_ready = 1'b0;
      pending.delete();
      exp_q.delete();
      req_pc = boot;
      mis = 1'b0;
      first_valid = -1;
      cyc = 0;
      pops = 0;
      grants = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
      chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
      chk("rst_instr_dec", bus.instr_dec, 32'd0);
      chk("rst_pc_dec", bus.pc_dec, boot);
      chk("rst_pc_plus4", bus.pc_plus4_dec, boot + 32'd4);
   endtask

   // Driver: one clock of stimulus, then imem/scoreboard bookkeeping after the monitor has sampled.
   task automatic step(input bit redir, input logic [31:0] rpc, input bit hlt,
                       input bit rdy, input bit gnt, input int lat);
      req_t r;
      @(negedge clk);
      rstn = 1'b1;
      mon_en = 1'b1;
      bus.redirect = redir;
      bus.redirect_pc = rpc;
      bus.halt = hlt;
      bus.dec_ready = rdy;
      bus.imem_gnt = gnt;
      if (pending.size() != 0 && pending[0].due <= cyc) begin
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata = mem_word(pending[0].addr);
      end else begin
         bus.imem_rvalid = 1'b0;
         bus.imem_rdata = $urandom;
      end
      #2;
      if (bus.imem_rvalid) begin
         r = pending.pop_front();
         if (r.epoch == epoch && !redir) exp_q.push_back('{r.pc, mem_word(r.pc)});
      end
      if (bus.imem_req && gnt) begin
         pending.push_back('{bus.imem_addr, req_pc, epoch, cyc + lat});
         req_pc = req_pc + 32'd4;
         grants++;
      end
      if (redir) begin
         epoch++;
         exp_q.delete();
         req_pc = rpc;
         mis = (rpc[1:0] != 2'b00);
      end
      cyc++;
   endtask

   // Monitor: checks request rule, fault outputs and every instruction DEC consumes.
   always @(negedge clk) begin
      bit   exp_req;
      exp_t e;
      #1;
      if (mon_en) begin
         exp_req = !bus.redirect && !bus.halt && !mis && (pending.size() < MAX_OUTST) &&
                   (exp_q.size() + pending.size() < DEPTH);
         chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
         if (exp_req) chk("imem_addr", bus.imem_addr, req_pc);
         chk("pc_misaligned", 32'(bus.pc_misaligned), 32'(mis));
         chk("fault_pc", bus.fault_pc, mis ? req_pc : 32'h0);
         chk("if_valid", 32'(bus.if_valid), 32'(exp_q.size() != 0));
         if (bus.if_valid && first_valid < 0) first_valid = cyc;
         if (bus.if_valid && bus.dec_ready && !bus.redirect) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL pop_unexpected: actual pc=%h expected no instruction (cycle %0d)",
                        bus.pc_dec, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("pc_dec", bus.pc_dec, e.pc);
               chk("instr_dec", bus.instr_dec, e.instr);
               chk("pc_plus4_dec", bus.pc_plus4_dec, e.pc + 32'd4);
               pops++;
            end
         end
      end
   end

   initial begin
      int          g0;
      int          p0;
      bit          redir;
      logic [31:0] rpc;
      rstn = 1'b0;
      bus.boot_addr = 32'h1000;
      bus.redirect = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.halt = 1'b0;
      bus.imem_gnt = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = 32'h0;
      bus.dec_ready = 1'b0;

      // sequential fetch, 1-cycle imem
      do_reset(32'h1000);
      repeat (20) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);
      chk("first_if_valid_cycle", first_valid, 32'd2);
      chk("steady_pops", pops, 32'd18);

      // backpressure saturates the FIFO at DEPTH
      do_reset(32'h1000);
      repeat (10) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1);
      chk("bp_grants", grants, 32'd4);
      chk("bp_head_pc", bus.pc_dec, 32'h1000);
      repeat (12) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);
      chk("bp_drained", pops, 32'd12);

      // redirect with two slow requests in flight
      do_reset(32'h1000);
      repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 3);
      step(1'b1, 32'h2000, 1'b0, 1'b1, 1'b1, 1);
      p0 = pops;
      repeat (15) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);
      chk("redir_resumed", 32'(pops - p0 >= 8), 32'd1);

      // redirect coinciding with a response and a pop
      repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);
      step(1'b1, 32'h2400, 1'b0, 1'b1, 1'b1, 1);
      repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);

      // misaligned target, then recovery
      step(1'b1, 32'h2002, 1'b0, 1'b1, 1'b1, 1);
      g0 = grants;
      repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);
      chk("misaligned_no_grant", grants - g0, 32'd0);
      chk("misaligned_fault_pc", bus.fault_pc, 32'h2002);
      step(1'b1, 32'h3000, 1'b0, 1'b1, 1'b1, 1);
      repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);

      // halt with two requests outstanding
      repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 3);
      g0 = grants;
      repeat (8) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1);
      chk("halt_no_grant", grants - g0, 32'd0);
      repeat (12) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1);

      // randomised traffic with a mid-run reset
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset(32'h4000);
         redir = ($urandom_range(0, 31) == 0);
         rpc = 32'h5000 + ($urandom_range(0, 255) << 2);
         if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFF0;
         step(redir, rpc, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) != 0), int'($urandom_range(1, 4)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
